im_fetch_ctrl: RTL and testbench

//   Fetch sequencer for the 16-bit pmips instruction memory (IM). Owns the PC,

---
 rtl/im_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_im_fetch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: pmips fetch sequencer. Owns the PC, drives the IM address,
// resolves J/JAL in fetch and captures words into a valid/ready IR for decode.
// Ports: clock, reset_n | run, halt_req, halted | iaddr, idata |
//        ir, ir_pc, ir_valid, ir_ready | redirect_valid, redirect_addr |
//        link_we, link_wreg, link_data.
`timescale 1ns/1ps
module im_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [2:0]  J_OP     = 3'd2,
  parameter logic [2:0]  JAL_OP   = 3'd1,
  parameter logic [2:0]  LINK_REG = 3'd7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        halt_req,
  output logic [15:0] iaddr,
  input  logic [15:0] idata,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  output logic        link_we,
  output logic [2:0]  link_wreg,
  output logic [15:0] link_data,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALT
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc2;
  logic [15:0] next_pc;
  logic [15:0] redir_pc;
  logic        jump;
  logic        slot_free;

  assign pc2       = pc + 16'd2;
  assign jump      = (idata[15:13] == J_OP) ||
                     (idata[15:13] == JAL_OP);
  // J/JAL target keeps the region bits of the sequential PC
  assign next_pc   = jump ? {pc2[15:14], idata[12:0], 1'b0} : pc2;
  assign redir_pc  = {redirect_addr[15:1], 1'b0};
  assign slot_free = !ir_valid || ir_ready;

  assign iaddr     = pc;
  assign link_wreg = LINK_REG;
  assign link_data = ir_pc + 16'd2;
  assign link_we   = ir_valid && ir_ready &&
                     (ir[15:13] == JAL_OP) && !redirect_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= {RESET_PC[15:1], 1'b0};
      ir       <= 16'h0000;
      ir_pc    <= 16'h0000;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run && !halt_req) state <= FETCH;
        end
        FETCH: begin
          if (redirect_valid) begin
            pc       <= redir_pc;
            ir_valid <= 1'b0;
          end else if (halt_req) begin
            if (ir_valid && !ir_ready) begin
              state <= DRAIN;
            end else begin
              ir_valid <= 1'b0;
              state    <= HALT;
              halted   <= 1'b1;
            end
          end else if (slot_free) begin
            ir       <= idata;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= next_pc;
          end
        end
        DRAIN: begin
          // a flush empties the IR just as a drain would
          if (redirect_valid) begin
            pc       <= redir_pc;
            ir_valid <= 1'b0;
            state    <= HALT;
            halted   <= 1'b1;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= HALT;
            halted   <= 1'b1;
          end
        end
        HALT: begin
          if (redirect_valid) begin
            pc <= redir_pc;
          end else if (run && !halt_req) begin
            state  <= FETCH;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb_im_fetch_ctrl: scoreboard bench for im_fetch_ctrl. A program-order
// walk of the IM predicts every word decode should accept.
`timescale 1ns/1ps
module tb_im_fetch_ctrl;

  logic        clock;
  logic        reset_n;
  logic        run;
  logic        halt_req;
  logic [15:0] iaddr;
  logic [15:0] idata;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        link_we;
  logic [2:0]  link_wreg;
  logic [15:0] link_data;
  logic        halted;

  logic [15:0] mem [0:32767];

  typedef struct {
    logic [15:0] word;
    logic [15:0] pc;
  } ent_t;

  ent_t        sbq[$];
  ent_t        me;
  logic [15:0] gen_pc;
  int          total;
  int          bad;
  int          hs;

  im_fetch_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .run            (run),
    .halt_req       (halt_req),
    .iaddr          (iaddr),
    .idata          (idata),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .link_we        (link_we),
    .link_wreg      (link_wreg),
    .link_data      (link_data),
    .halted         (halted)
  );

  assign idata = mem[iaddr[15:1]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // next architectural PC after executing word w located at p
  function automatic logic [15:0] model_next(input logic [15:0] p,
                                             input logic [15:0] w);
    logic [15:0] s;
    s = p + 16'd2;
    if (w[15:13] == 3'd1 || w[15:13] == 3'd2)
      return (s & 16'hC000) | {2'b00, w[12:0], 1'b0};
    return s;
  endfunction

  task automatic refill();
    ent_t e;
    while (sbq.size() < 8) begin
      e.pc   = gen_pc;
      e.word = mem[gen_pc[15:1]];
      sbq.push_back(e);
      gen_pc = model_next(gen_pc, e.word);
    end
  endtask

  task automatic apply(input logic r, input logic h, input logic rdy,
                       input logic rv, input logic [15:0] ra);
    run            = r;
    halt_req       = h;
    ir_ready       = rdy;
    redirect_valid = rv;
    redirect_addr  = ra;
    if (rv) begin
      sbq.delete();
      gen_pc = {ra[15:1], 1'b0};
    end
    refill();
    #3;
  endtask

  task automatic cyc(input logic r, input logic h, input logic rdy,
                     input logic rv, input logic [15:0] ra);
    @(negedge clock);
    apply(r, h, rdy, rv, ra);
  endtask

  // monitor: every accepted word must be the next one in program order
  always @(negedge clock) begin
    #2;
    if (reset_n) begin
      if (ir_valid && ir_ready && !redirect_valid) begin
        hs++;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty ir=%h ir_pc=%h", ir, ir_pc);
        end else begin
          me = sbq.pop_front();
          chk("ir", ir, me.word);
          chk("ir_pc", ir_pc, me.pc);
          chk("link_we", {15'd0, link_we},
              {15'd0, me.word[15:13] == 3'd1});
          if (me.word[15:13] == 3'd1) begin
            chk("link_data", link_data, me.pc + 16'd2);
            chk("link_wreg", {13'd0, link_wreg}, 16'd7);
          end
        end
      end else begin
        chk("link_we_quiet", {15'd0, link_we}, 16'd0);
      end
    end
  end

  logic [15:0] exp_ia [0:5];
  logic [15:0] r_ir;
  logic [15:0] r_pc;
  logic [15:0] r_ia;
  logic        found;
  logic        rr;
  logic        rh;
  logic        rrdy;
  logic        rrv;
  logic [15:0] rra;
  int          hold;

  initial begin
    total = 0;
    bad   = 0;
    hs    = 0;
    gen_pc = 16'h0000;
    reset_n = 1'b1;
    run = 1'b0;
    halt_req = 1'b0;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 16'h0000;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0]      = 16'h8041;
    mem[1]      = 16'h8082;
    mem[2]      = 16'h80C3;
    mem[3]      = 16'h8104;
    mem[4]      = 16'h2001;
    mem[16'h18] = 16'h2020;
    mem[16'h7FFE] = 16'h8145;
    mem[16'h7FFF] = 16'h8186;
    exp_ia[0] = 16'h0000;
    exp_ia[1] = 16'h0002;
    exp_ia[2] = 16'h0004;
    exp_ia[3] = 16'h0006;
    exp_ia[4] = 16'h0008;
    exp_ia[5] = 16'h0002;

    #1 reset_n = 1'b0;
    #1;
    chk("rst_iaddr", iaddr, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ir_pc", ir_pc, 16'h0000);
    chk("rst_valid", {15'd0, ir_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_link_we", {15'd0, link_we}, 16'd0);

    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    apply(1, 0, 1, 0, 16'h0);

    // straight-line fetch, then JAL @8 to 0x0002
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 1, 0, 16'h0);
      chk("seq_iaddr", iaddr, exp_ia[k]);
    end
    chk("jal_link_we", {15'd0, link_we}, 16'd1);
    chk("jal_link_data", link_data, 16'h000A);
    chk("jal_link_wreg", {13'd0, link_wreg}, 16'd7);

    // 3-cycle decode stall
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 16'h0);
      if (k == 0) begin
        chk("stall_valid", {15'd0, ir_valid}, 16'd1);
        r_ir = ir;
        r_pc = ir_pc;
        r_ia = iaddr;
      end else begin
        chk("stall_ir", ir, r_ir);
        chk("stall_ir_pc", ir_pc, r_pc);
        chk("stall_iaddr", iaddr, r_ia);
      end
    end

    // redirect while the JAL at 0x0008 is on idata
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (iaddr == 16'h0008) begin
        found = 1'b1;
        break;
      end
      apply(1, 0, 1, 0, 16'h0);
    end
    chk("wait_jal_fetch", {15'd0, found}, 16'd1);
    if (found) begin
      apply(1, 0, 1, 1, 16'h0031);
      chk("redir_link_we", {15'd0, link_we}, 16'd0);
      cyc(1, 0, 1, 0, 16'h0);
      chk("redir_iaddr", iaddr, 16'h0030);
      chk("redir_flush", {15'd0, ir_valid}, 16'd0);
      // JAL sits in ir with ready=1: redirect must suppress the link write
      @(negedge clock);
      apply(1, 0, 1, 1, 16'h0004);
      chk("sup_ir", ir, 16'h2020);
      chk("sup_link_we", {15'd0, link_we}, 16'd0);
    end

    // halt with an instruction pending
    cyc(1, 0, 0, 0, 16'h0);
    chk("halt_pre_valid", {15'd0, ir_valid}, 16'd0);
    cyc(1, 1, 0, 0, 16'h0);
    chk("halt_pend", {15'd0, ir_valid}, 16'd1);
    cyc(1, 1, 0, 0, 16'h0);
    chk("drain_halted", {15'd0, halted}, 16'd0);
    chk("drain_valid", {15'd0, ir_valid}, 16'd1);
    r_ia = iaddr;
    cyc(1, 1, 1, 0, 16'h0);
    cyc(1, 1, 1, 0, 16'h0);
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_valid", {15'd0, ir_valid}, 16'd0);
    chk("halt_iaddr", iaddr, r_ia);
    cyc(1, 0, 1, 0, 16'h0);
    chk("resume_still", {15'd0, halted}, 16'd1);
    cyc(1, 0, 1, 0, 16'h0);
    chk("resume_halted", {15'd0, halted}, 16'd0);
    chk("resume_iaddr", iaddr, r_ia);

    // PC wrap
    cyc(1, 0, 1, 1, 16'hFFFC);
    cyc(1, 0, 1, 0, 16'h0);
    chk("wrap_fffc", iaddr, 16'hFFFC);
    cyc(1, 0, 1, 0, 16'h0);
    chk("wrap_fffe", iaddr, 16'hFFFE);
    cyc(1, 0, 1, 0, 16'h0);
    chk("wrap_0000", iaddr, 16'h0000);

    // reset in the middle of a stall
    cyc(1, 0, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);
    chk("mid_valid", {15'd0, ir_valid}, 16'd1);
    reset_n = 1'b0;
    sbq.delete();
    gen_pc = 16'h0000;
    #1;
    chk("mrst_iaddr", iaddr, 16'h0000);
    chk("mrst_ir", ir, 16'h0000);
    chk("mrst_ir_pc", ir_pc, 16'h0000);
    chk("mrst_valid", {15'd0, ir_valid}, 16'd0);
    chk("mrst_halted", {15'd0, halted}, 16'd0);
    chk("mrst_link_we", {15'd0, link_we}, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    apply(1, 0, 1, 0, 16'h0);

    // randomized traffic
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0 && $urandom_range(0, 39) == 0)
        hold = $urandom_range(1, 6);
      rh = (hold != 0);
      if (hold != 0) hold--;
      rr   = 1'($urandom_range(0, 1));
      rrdy = ($urandom_range(0, 9) < 7);
      rrv  = ($urandom_range(0, 24) == 0);
      rra  = 16'($urandom);
      cyc(rr, rh, rrdy, rrv, rra);
    end
    chk("progress", {15'd0, hs > 500}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
